seg_decoder: RTL and testbench
==============================

SEG_DECODER -- requirements
Module: seg_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, SHALL set the consecutive identical samples required before a pattern is accepted; legal range 1..255.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-004 seg  input  7  segment bus {g,f,e,d,c,b,a}, active-low (0 = segment lit), asynchronous to the decoder's view of time.
REQ-005 ready  input  1  consumer accepts the current result when high together with valid.
REQ-006 digit  output  4  decoded value 0..9, or 4'hF for an illegal pattern.
REQ-007 err  output  1  high with valid when the accepted pattern is not a legal digit.
REQ-008 valid  output  1  result available; held until accepted.

Function
REQ-009 seg SHALL be registered once per cycle; all decisions SHALL use registered samples only.
REQ-010 An 8-bit saturating stability counter SHALL clear when a new sample differs from the previous sample and increment otherwise.
REQ-011 A pattern SHALL be stable once seg has held one value for STABLE_CYCLES consecutive rising edges.
REQ-012 Timing: if seg changes before edge 1 and holds, valid SHALL rise after edge STABLE_CYCLES+1, and not earlier.
REQ-013 Decode table (hex, active-low): 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9.
REQ-014 7'h7F (blank) SHALL never produce valid; it SHALL still update the last-reported pattern.
REQ-015 Any other stable pattern SHALL produce valid=1, err=1, digit=4'hF.
REQ-016 A stable pattern SHALL be reported only if it differs from the last-reported pattern; one report per distinct stable pattern.
REQ-017 FSM states:
- IDLE: valid=0.
- HOLD: valid=1; digit and err frozen.
REQ-018 IDLE->HOLD SHALL occur on a reportable stable pattern.
REQ-019 HOLD->IDLE SHALL occur on the edge where valid&&ready; the last-reported pattern SHALL update at transfer.
REQ-020 With ready held high, valid SHALL be high for exactly one cycle per report.
REQ-021 In HOLD, sampling and counting SHALL continue.
- A different pattern stabilizing in HOLD SHALL NOT alter outputs.
- It SHALL be reported in the cycle after transfer if it is still the stable sample and differs from the transferred pattern.
REQ-022 Glitch rejection: a value held fewer than STABLE_CYCLES edges SHALL produce no report; the counter restarts on the next value.
REQ-023 With valid=0, ready SHALL be ignored.
REQ-024 In IDLE, digit and err SHALL retain their last values.

Reset
REQ-025 When rst=1 at an edge:
- valid=0, err=0, digit=4'h0, FSM=IDLE.
- counter=0; sample register and last-reported pattern = 7'h7F.
REQ-026 rst SHALL override all other activity, including a pending HOLD; the pending result SHALL be discarded.
REQ-027 After rst deasserts, a non-blank seg held constant SHALL be reported once per REQ-012, counting from the first edge with rst=0.

Verification (STABLE_CYCLES=4, ready=1 unless stated)
REQ-028 seg=7'h24 held from edge 1 -> valid=1, digit=2, err=0 after edge 5 only; single-cycle pulse; no further reports while held.
REQ-029 seg 7'h40 for 2 edges, then 7'h79 held -> no report for 0; exactly one report of digit=1.
REQ-030 ready=0, seg=7'h10 stable -> valid=1, digit=9, held; seg changes to 7'h02 and stabilizes; ready=1 -> 9 transfers; next cycle valid=1, digit=6.
REQ-031 seg=7'h7F, then 7'h55, each held -> blank gives no valid; 7'h55 gives valid=1, err=1, digit=F.
REQ-032 seg=7'h00 reported; blank 7'h7F stable; 7'h00 again -> second report of 8 (blank reset the duplicate filter).
REQ-033 rst pulsed while valid=1 with ready=0 -> valid=0, digit=0 next cycle; same seg held -> re-reported after 5 edges.

Source files
------------

// File: rtl/seg_decoder.sv
// Seven-segment pattern decoder: debounces an active-low segment bus, decodes
// stable patterns to a digit and offers each new one over a valid/ready handshake.
module seg_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg,
    input  logic       ready,
    output logic [3:0] digit,
    output logic       err,
    output logic       valid
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam logic [6:0] SEG_BLANK     = 7'h7F;
    // Counter value reached once the sample has been seen on STABLE_CYCLES edges.
    localparam logic [7:0] STABLE_THRESH = 8'(STABLE_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [6:0]  r_seg;
    logic [7:0]  r_cnt;
    logic [6:0]  r_last;
    logic [6:0]  w_last_next;
    logic [6:0]  r_pat;
    logic [3:0]  r_digit;
    logic        r_err;
    logic        w_load;
    logic        w_stable;
    logic        w_blank;
    logic        w_reportable;
    logic [3:0]  w_dec_digit;
    logic        w_dec_err;

    assign w_stable     = (r_cnt >= STABLE_THRESH);
    assign w_blank      = (r_seg == SEG_BLANK);
    assign w_reportable = w_stable && !w_blank && (r_seg != r_last);

    always_comb begin
        w_dec_digit = 4'hF;
        w_dec_err   = 1'b0;
        case (r_seg)
            7'h40:   w_dec_digit = 4'd0;
            7'h79:   w_dec_digit = 4'd1;
            7'h24:   w_dec_digit = 4'd2;
            7'h30:   w_dec_digit = 4'd3;
            7'h19:   w_dec_digit = 4'd4;
            7'h12:   w_dec_digit = 4'd5;
            7'h02:   w_dec_digit = 4'd6;
            7'h78:   w_dec_digit = 4'd7;
            7'h00:   w_dec_digit = 4'd8;
            7'h10:   w_dec_digit = 4'd9;
            default: w_dec_err   = 1'b1;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_last_next  = r_last;
        w_load       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A stable blank clears the duplicate filter without reporting.
                if (w_stable && w_blank) begin
                    w_last_next = SEG_BLANK;
                end else if (w_reportable) begin
                    w_state_next = ST_HOLD;
                    w_load       = 1'b1;
                end
            end
            ST_HOLD: begin
                if (ready) begin
                    w_state_next = ST_IDLE;
                    w_last_next  = r_pat;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_seg   <= SEG_BLANK;
            r_cnt   <= 8'd0;
            r_last  <= SEG_BLANK;
            r_pat   <= SEG_BLANK;
            r_digit <= 4'h0;
            r_err   <= 1'b0;
        end else begin
            r_seg <= seg;
            if (seg != r_seg) begin
                r_cnt <= 8'd0;
            end else if (r_cnt != 8'hFF) begin
                r_cnt <= r_cnt + 8'd1;
            end
            r_state <= w_state_next;
            r_last  <= w_last_next;
            if (w_load) begin
                r_pat   <= r_seg;
                r_digit <= w_dec_digit;
                r_err   <= w_dec_err;
            end
        end
    end

    assign valid = (r_state == ST_HOLD);
    assign digit = r_digit;
    assign err   = r_err;

endmodule

// File: tb/tb_seg_decoder.sv
// Bench for seg_decoder: directed scenarios with fixed expectations, then a
// randomized run compared cycle by cycle against a run-length reference model.
module tb_seg_decoder;

    localparam int STABLE = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] seg = 7'h7F;
    logic       ready = 1'b1;
    logic [3:0] digit;
    logic       err;
    logic       valid;

    int n_checks = 0;
    int n_fail   = 0;
    int n_xfer   = 0;

    seg_decoder #(.STABLE_CYCLES(STABLE)) dut (
        .clk   (clk),
        .rst   (rst),
        .seg   (seg),
        .ready (ready),
        .digit (digit),
        .err   (err),
        .valid (valid)
    );

    always #5 clk = ~clk;

    // Reference model: how long the sampled value has been held, what was
    // last reported, and whether a result is waiting for the consumer.
    logic [6:0] m_run_val;
    int         m_run_len;
    logic [6:0] m_last;
    logic       m_hold;
    logic [6:0] m_pat;
    logic [3:0] m_digit;
    logic       m_err;
    logic [6:0] pat_table [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                   7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    task automatic model_edge(input logic [6:0] s, input logic r, input logic rs);
        if (rs) begin
            m_run_val = 7'h7F; m_run_len = 0; m_last = 7'h7F;
            m_hold = 1'b0; m_pat = 7'h7F; m_digit = 4'h0; m_err = 1'b0;
        end else begin
            if (m_hold) begin
                if (r) begin
                    m_hold = 1'b0;
                    m_last = m_pat;
                end
            end else if (m_run_len >= STABLE) begin
                if (m_run_val == 7'h7F) begin
                    m_last = 7'h7F;
                end else if (m_run_val != m_last) begin
                    m_hold  = 1'b1;
                    m_pat   = m_run_val;
                    m_digit = 4'hF;
                    m_err   = 1'b1;
                    for (int i = 0; i < 10; i++) begin
                        if (pat_table[i] == m_run_val) begin
                            m_digit = 4'(i);
                            m_err   = 1'b0;
                        end
                    end
                end
            end
            if (s == m_run_val) begin
                m_run_len++;
            end else begin
                m_run_val = s;
                m_run_len = 1;
            end
        end
    endtask

    // Drive one cycle of inputs, take the edge, then settle before sampling.
    task automatic step(input logic [6:0] s, input logic r, input logic rs);
        seg = s; ready = r; rst = rs;
        @(posedge clk);
        if (valid && r && !rs) begin
            n_xfer++;
            $display("xfer %0d: digit=%h err=%0b t=%0t", n_xfer, digit, err, $time);
        end
        model_edge(s, r, rs);
        #1;
    endtask

    task automatic test_reset();
        step(7'h24, 1'b1, 1'b1);
        step(7'h24, 1'b1, 1'b1);
        n_checks++;
        if (valid !== 1'b0 || err !== 1'b0 || digit !== 4'h0) begin
            n_fail++;
            $display("FAIL reset: valid=%b err=%b digit=%h, want 0 0 0", valid, err, digit);
        end
    endtask

    task automatic test_basic();
        step(7'h7F, 1'b1, 1'b1);
        for (int k = 1; k <= 12; k++) begin
            step(7'h24, 1'b1, 1'b0);
            n_checks++;
            if (valid !== (k == 5)) begin
                n_fail++;
                $display("FAIL basic_valid edge %0d: valid=%b want %b", k, valid, (k == 5));
            end
            if (k == 5) begin
                n_checks++;
                if (digit !== 4'd2 || err !== 1'b0) begin
                    n_fail++;
                    $display("FAIL basic_data: digit=%h err=%b want 2 0", digit, err);
                end
            end
        end
    endtask

    task automatic test_glitch();
        step(7'h7F, 1'b1, 1'b1);
        for (int k = 1; k <= 14; k++) begin
            step((k <= 2) ? 7'h40 : 7'h79, 1'b1, 1'b0);
            n_checks++;
            if (valid !== (k == 7)) begin
                n_fail++;
                $display("FAIL glitch_valid edge %0d: valid=%b want %b", k, valid, (k == 7));
            end
            if (valid && digit !== 4'd1) begin
                n_checks++;
                n_fail++;
                $display("FAIL glitch_digit: digit=%h want 1", digit);
            end
        end
    endtask

    task automatic test_backpressure();
        step(7'h7F, 1'b0, 1'b1);
        for (int k = 1; k <= 8; k++) step(7'h10, 1'b0, 1'b0);
        n_checks++;
        if (valid !== 1'b1 || digit !== 4'd9) begin
            n_fail++;
            $display("FAIL bp_first: valid=%b digit=%h want 1 9", valid, digit);
        end
        for (int k = 1; k <= 8; k++) begin
            step(7'h02, 1'b0, 1'b0);
            n_checks++;
            if (valid !== 1'b1 || digit !== 4'd9 || err !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_frozen edge %0d: valid=%b digit=%h err=%b want 1 9 0", k, valid, digit, err);
            end
        end
        step(7'h02, 1'b1, 1'b0);
        n_checks++;
        if (valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_xfer: valid=%b want 0", valid);
        end
        step(7'h02, 1'b1, 1'b0);
        n_checks++;
        if (valid !== 1'b1 || digit !== 4'd6) begin
            n_fail++;
            $display("FAIL bp_second: valid=%b digit=%h want 1 6", valid, digit);
        end
        step(7'h02, 1'b1, 1'b0);
        n_checks++;
        if (valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_pulse: valid=%b want 0", valid);
        end
    endtask

    task automatic test_blank_illegal();
        step(7'h7F, 1'b1, 1'b1);
        for (int k = 1; k <= 10; k++) begin
            step(7'h7F, 1'b1, 1'b0);
            n_checks++;
            if (valid !== 1'b0) begin
                n_fail++;
                $display("FAIL blank_valid edge %0d: valid=%b want 0", k, valid);
            end
        end
        for (int k = 1; k <= 8; k++) begin
            step(7'h55, 1'b1, 1'b0);
            n_checks++;
            if (valid !== (k == 5)) begin
                n_fail++;
                $display("FAIL illegal_valid edge %0d: valid=%b want %b", k, valid, (k == 5));
            end
            if (k == 5) begin
                n_checks++;
                if (err !== 1'b1 || digit !== 4'hF) begin
                    n_fail++;
                    $display("FAIL illegal_data: err=%b digit=%h want 1 F", err, digit);
                end
            end
        end
    endtask

    task automatic test_blank_refilter();
        logic [6:0] phase_seg [3] = '{7'h00, 7'h7F, 7'h00};
        int         phase_want [3] = '{1, 0, 1};
        step(7'h7F, 1'b1, 1'b1);
        for (int p = 0; p < 3; p++) begin
            int reports = 0;
            for (int k = 1; k <= 8; k++) begin
                step(phase_seg[p], 1'b1, 1'b0);
                if (valid) begin
                    reports++;
                    n_checks++;
                    if (digit !== 4'd8 || err !== 1'b0) begin
                        n_fail++;
                        $display("FAIL refilter_data phase %0d: digit=%h err=%b want 8 0", p, digit, err);
                    end
                end
            end
            n_checks++;
            if (reports != phase_want[p]) begin
                n_fail++;
                $display("FAIL refilter_count phase %0d: reports=%0d want %0d", p, reports, phase_want[p]);
            end
        end
    endtask

    task automatic test_reset_pending();
        step(7'h7F, 1'b0, 1'b1);
        for (int k = 1; k <= 6; k++) step(7'h30, 1'b0, 1'b0);
        n_checks++;
        if (valid !== 1'b1 || digit !== 4'd3) begin
            n_fail++;
            $display("FAIL rstpend_before: valid=%b digit=%h want 1 3", valid, digit);
        end
        step(7'h30, 1'b0, 1'b1);
        n_checks++;
        if (valid !== 1'b0 || digit !== 4'h0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL rstpend_cleared: valid=%b digit=%h err=%b want 0 0 0", valid, digit, err);
        end
        for (int k = 1; k <= 7; k++) begin
            step(7'h30, 1'b0, 1'b0);
            n_checks++;
            if (valid !== (k >= 5)) begin
                n_fail++;
                $display("FAIL rstpend_again edge %0d: valid=%b want %b", k, valid, (k >= 5));
            end
        end
        n_checks++;
        if (digit !== 4'd3) begin
            n_fail++;
            $display("FAIL rstpend_digit: digit=%h want 3", digit);
        end
    endtask

    task automatic test_random();
        logic [6:0] choices [14] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02,
                                     7'h78, 7'h00, 7'h10, 7'h7F, 7'h7F, 7'h55, 7'h3C};
        int         cycles = 0;
        int         shown  = 0;
        step(7'h7F, 1'b1, 1'b1);
        while (cycles < 3000) begin
            logic [6:0] s    = choices[$urandom_range(0, 13)];
            int         hold = $urandom_range(1, 8);
            for (int h = 0; h < hold; h++) begin
                logic r  = ($urandom_range(0, 3) != 0);
                logic rs = ($urandom_range(0, 299) == 0);
                step(s, r, rs);
                cycles++;
                n_checks++;
                if (valid !== m_hold || digit !== m_digit || err !== m_err) begin
                    n_fail++;
                    if (shown < 20) begin
                        shown++;
                        $display("FAIL random cycle %0d: valid=%b digit=%h err=%b want %b %h %b",
                                 cycles, valid, digit, err, m_hold, m_digit, m_err);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_backpressure();
        test_blank_illegal();
        test_blank_refilter();
        test_reset_pending();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
